// File: rtl/i2c_init_seq.sv
// Command-table sequencer feeding a byte-level I2C master: walks a ROM of
// WR / RD / DLY / END entries, checks readbacks and reports the first failure.
module i2c_init_seq #(
    parameter int ADDR_W   = 6,
    parameter int DLY_UNIT = 1000,
    parameter int ACK_TO   = 4096
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] cmd_addr_o,
    input  logic [17:0]       cmd_data_i,
    output logic [7:0]        word_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              wr_start_flag_o,
    output logic              rd_start_flag_o,
    input  logic              i2c_busy_i,
    input  logic [7:0]        rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o,
    output logic [ADDR_W-1:0] err_idx_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_HI,
        S_WAIT_LO, S_CHECK, S_DELAY, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_END = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_DLY = 2'b11
    } op_t;

    localparam int DLY_W = $clog2(255 * DLY_UNIT + 1);
    localparam int TO_W  = $clog2(ACK_TO + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state, state_nxt;
    op_t               op_in, op_q;
    logic [ADDR_W-1:0] idx;
    logic [DLY_W-1:0]  dly_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              tmo_q;
    logic [7:0]        rd_q;
    logic              at_last, to_hit, dly_last, dly_none, entry_fail;
    state_t            adv_state;

    assign op_in      = op_t'(cmd_data_i[17:16]);
    assign at_last    = (idx == LAST_IDX);
    assign to_hit     = (to_cnt >= TO_W'(ACK_TO - 1));
    assign dly_last   = (dly_cnt <= DLY_W'(1));
    assign dly_none   = (cmd_data_i[7:0] == 8'd0);
    // wr_data_o doubles as the expected value while an RD entry is active
    assign entry_fail = tmo_q || ((op_q == OP_RD) && (rd_q != wr_data_o));
    assign adv_state  = at_last ? S_FIN : S_FETCH;
    assign cmd_addr_o = idx;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Handshake with the master: a start flag is a level request held until
    // i2c_busy_i is seen high (acknowledge) or ACK_TO cycles pass; completion
    // is i2c_busy_i falling, and rd_data_i is valid on that cycle.
    always_comb begin
        state_nxt       = state;
        wr_start_flag_o = 1'b0;
        rd_start_flag_o = 1'b0;
        busy_o          = (state != S_IDLE);
        done_o          = 1'b0;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op_in)
                    OP_END:  state_nxt = S_FIN;
                    OP_DLY:  state_nxt = dly_none ? adv_state : S_DELAY;
                    default: state_nxt = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                wr_start_flag_o = (op_q == OP_WR);
                rd_start_flag_o = (op_q == OP_RD);
                state_nxt       = i2c_busy_i ? S_WAIT_LO : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                wr_start_flag_o = (op_q == OP_WR);
                rd_start_flag_o = (op_q == OP_RD);
                if (i2c_busy_i)  state_nxt = S_WAIT_LO;
                else if (to_hit) state_nxt = S_CHECK;
            end
            S_WAIT_LO: if (!i2c_busy_i) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = adv_state;
            S_DELAY:   if (dly_last) state_nxt = adv_state;
            S_FIN: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            idx         <= '0;
            op_q        <= OP_END;
            word_addr_o <= 8'd0;
            wr_data_o   <= 8'd0;
            dly_cnt     <= '0;
            to_cnt      <= '0;
            tmo_q       <= 1'b0;
            rd_q        <= 8'd0;
            err_o       <= 1'b0;
            err_cnt_o   <= 8'd0;
            err_idx_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        idx       <= '0;
                        err_o     <= 1'b0;
                        err_cnt_o <= 8'd0;
                        err_idx_o <= '0;
                    end
                end
                S_DECODE: begin
                    op_q    <= op_in;
                    to_cnt  <= '0;
                    tmo_q   <= 1'b0;
                    dly_cnt <= DLY_W'(cmd_data_i[7:0]) * DLY_W'(DLY_UNIT);
                    if (op_in == OP_WR || op_in == OP_RD) begin
                        word_addr_o <= cmd_data_i[15:8];
                        wr_data_o   <= cmd_data_i[7:0];
                    end
                    if (op_in == OP_DLY && dly_none && !at_last) idx <= idx + ADDR_W'(1);
                end
                S_ISSUE: to_cnt <= to_cnt + TO_W'(1);
                S_WAIT_HI: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (!i2c_busy_i && to_hit) tmo_q <= 1'b1;
                end
                S_WAIT_LO: if (!i2c_busy_i) rd_q <= rd_data_i;
                S_CHECK: begin
                    if (entry_fail) begin
                        err_o <= 1'b1;
                        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                        if (!err_o) err_idx_o <= idx;
                    end
                    if (!at_last) idx <= idx + ADDR_W'(1);
                end
                S_DELAY: begin
                    if (dly_last) begin
                        if (!at_last) idx <= idx + ADDR_W'(1);
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: ROM model, byte-master model with a write
// log checked against an expected queue, and negedge protocol monitors.
module tb_i2c_init_seq;

    localparam int ADDR_W   = 4;
    localparam int DLY_UNIT = 10;
    localparam int ACK_TO   = 16;
    localparam int N_ENT    = 1 << ADDR_W;
    localparam logic [7:0] DEAD_ADDR = 8'hEE;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [ADDR_W-1:0] cmd_addr;
    logic [17:0]       cmd_data;
    logic [7:0]        word_addr, wr_data, rd_data;
    logic              wr_flag, rd_flag, i2c_busy;
    logic              busy, done, err;
    logic [7:0]        err_cnt;
    logic [ADDR_W-1:0] err_idx;

    always #5 clk = ~clk;

    i2c_init_seq #(.ADDR_W(ADDR_W), .DLY_UNIT(DLY_UNIT), .ACK_TO(ACK_TO)) dut (
        .sys_clk_i       (clk),
        .rst_i           (rst),
        .start_i         (start),
        .cmd_addr_o      (cmd_addr),
        .cmd_data_i      (cmd_data),
        .word_addr_o     (word_addr),
        .wr_data_o       (wr_data),
        .wr_start_flag_o (wr_flag),
        .rd_start_flag_o (rd_flag),
        .i2c_busy_i      (i2c_busy),
        .rd_data_i       (rd_data),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .err_cnt_o       (err_cnt),
        .err_idx_o       (err_idx)
    );

    // ---------------- command ROM (one cycle latency) ----------------
    logic [17:0] rom [N_ENT];
    always @(posedge clk) cmd_data <= rom[cmd_addr];

    function automatic logic [17:0] e_wr(input logic [7:0] a, input logic [7:0] d);
        return {2'b01, a, d};
    endfunction
    function automatic logic [17:0] e_rd(input logic [7:0] a, input logic [7:0] d);
        return {2'b10, a, d};
    endfunction
    function automatic logic [17:0] e_dly(input logic [7:0] n);
        return {2'b11, 8'h00, n};
    endfunction

    // ---------------- byte master model ----------------
    int          m_delay = 3;
    int          m_len   = 200;
    logic        m_active = 1'b0;
    logic        m_is_rd;
    logic [7:0]  m_a, m_d;
    logic [7:0]  slave_mem [256];
    logic [15:0] log_wr [256];
    int          log_n = 0;

    initial begin
        i2c_busy = 1'b0;
        rd_data  = 8'h00;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'hAA;
        forever begin
            @(posedge clk); #1;
            if ((wr_flag || rd_flag) && word_addr != DEAD_ADDR) begin
                m_is_rd  = rd_flag;
                m_a      = word_addr;
                m_d      = wr_data;
                m_active = 1'b1;
                repeat (m_delay) @(posedge clk);
                #1 i2c_busy = 1'b1;
                repeat (m_len) @(posedge clk);
                #1;
                if (m_is_rd) begin
                    rd_data = slave_mem[m_a];
                end else begin
                    slave_mem[m_a]      = m_d;
                    log_wr[log_n % 256] = {m_a, m_d};
                    log_n               = log_n + 1;
                end
                i2c_busy = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    int                cyc = 0, done_cnt = 0, done_cyc = 0;
    int                wr_rise = 0, rd_rise = 0, both_hi = 0, stray = 0, wrap_cnt = 0;
    int                wr_run = 0;
    int                wr_len [256];
    logic              wr_d = 1'b0, rd_d = 1'b0, busy_d = 1'b0;
    logic [ADDR_W-1:0] addr_d = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (wr_flag && !wr_d) wr_rise <= wr_rise + 1;
        if (rd_flag && !rd_d) rd_rise <= rd_rise + 1;
        if (wr_flag && rd_flag) both_hi <= both_hi + 1;
        if ((wr_flag || rd_flag) && !busy) stray <= stray + 1;
        if (wr_flag) begin
            wr_run <= wr_run + 1;
        end else begin
            if (wr_d) wr_len[wr_rise % 256] <= wr_run;
            wr_run <= 0;
        end
        if (busy && busy_d && addr_d == '1 && cmd_addr == '0) wrap_cnt <= wrap_cnt + 1;
        wr_d   <= wr_flag;
        rd_d   <= rd_flag;
        busy_d <= busy;
        addr_d <= cmd_addr;
    end

    // ---------------- checking and scoreboard ----------------
    int          n_tests = 0, n_fail = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_drain(input string tag, input int l0);
        int i = l0;
        check({tag, "_wr_count"}, log_n - l0, exp_q.size());
        while (exp_q.size() > 0) begin
            logic [15:0] e = exp_q.pop_front();
            if (i < log_n) check({tag, "_wr"}, log_wr[i % 256], e);
            i++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int d0 = done_cnt;
        logic seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (done_cnt != d0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        repeat (3) tick();
    endtask

    task automatic clear_rom;
        for (int i = 0; i < N_ENT; i++) rom[i] = 18'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, r0, l0, c0, wr0;
        logic seen;
        rst   = 1'b1;
        start = 1'b0;
        clear_rom();
        repeat (3) tick();
        // reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        check("rst_err_idx", err_idx, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_word_addr", word_addr, 8'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_flags", {wr_flag, rd_flag}, 2'b00);
        rst = 1'b0;
        repeat (2) tick();

        // single write; a second start while busy must be ignored
        clear_rom();
        rom[0] = e_wr(8'h0F, 8'hF0);
        m_delay = 3; m_len = 200;
        d0 = done_cnt; w0 = wr_rise; l0 = log_n;
        exp_q.push_back({8'h0F, 8'hF0});
        pulse_start();
        repeat (20) tick();
        check("t1_busy_mid", busy, 1'b1);
        pulse_start();
        wait_done("t1", 400);
        check("t1_word_addr", word_addr, 8'h0F);
        check("t1_wr_data", wr_data, 8'hF0);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_wr_txns", wr_rise - w0, 1);
        check("t1_flag_len", wr_len[(w0 + 1) % 256], m_delay + 1);
        check("t1_err", err, 1'b0);
        check("t1_err_cnt", err_cnt, 8'd0);
        check("t1_busy_end", busy, 1'b0);
        sb_drain("t1", l0);

        // write then two readbacks, the second mismatching (slave returns 0xAA)
        clear_rom();
        rom[0] = e_wr(8'h0F, 8'hF0);
        rom[1] = e_rd(8'h0F, 8'hF0);
        rom[2] = e_rd(8'h10, 8'h55);
        m_delay = 2; m_len = 5;
        d0 = done_cnt; r0 = rd_rise;
        pulse_start();
        wait_done("t2", 300);
        check("t2_done_pulses", done_cnt - d0, 1);
        check("t2_rd_txns", rd_rise - r0, 2);
        check("t2_err", err, 1'b1);
        check("t2_err_cnt", err_cnt, 8'd1);
        check("t2_err_idx", err_idx, 2);

        // delay entry: 3*10 cycles; start cycle to done cycle is 35 =
        // 30 in DELAY + IDLE(start) + FETCH/DECODE of DLY + FETCH/DECODE of END
        clear_rom();
        rom[0] = e_dly(8'd3);
        d0 = done_cnt; w0 = wr_rise; r0 = rd_rise;
        c0 = cyc;
        pulse_start();
        wait_done("t3", 100);
        check("t3_done_pulses", done_cnt - d0, 1);
        check("t3_latency", done_cyc - c0, 35);
        check("t3_no_flags", (wr_rise - w0) + (rd_rise - r0), 0);

        // unanswered write times out after ACK_TO; sequencer moves on
        clear_rom();
        rom[0] = e_wr(8'h30, 8'h5A);
        rom[1] = e_wr(DEAD_ADDR, 8'h01);
        rom[2] = e_rd(8'h30, 8'h5A);
        m_delay = 1; m_len = 3;
        d0 = done_cnt; w0 = wr_rise; r0 = rd_rise;
        pulse_start();
        wait_done("t4", 300);
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_timeout_flag_len", wr_len[(w0 + 2) % 256], ACK_TO);
        check("t4_err", err, 1'b1);
        check("t4_err_cnt", err_cnt, 8'd1);
        check("t4_err_idx", err_idx, 1);
        check("t4_rd_after_timeout", rd_rise - r0, 1);

        // full table of writes, no END entry
        clear_rom();
        for (int k = 0; k < N_ENT; k++) begin
            rom[k] = e_wr(8'(8'h40 + k), 8'(3 * k + 1));
            exp_q.push_back({8'(8'h40 + k), 8'(3 * k + 1)});
        end
        m_delay = 1; m_len = 2;
        d0 = done_cnt; w0 = wr_rise; l0 = log_n; wr0 = wrap_cnt;
        pulse_start();
        wait_done("t5", 1500);
        check("t5_done_pulses", done_cnt - d0, 1);
        check("t5_wr_txns", wr_rise - w0, N_ENT);
        check("t5_no_wrap", wrap_cnt - wr0, 0);
        check("t5_err_cleared", err, 1'b0);
        check("t5_err_cnt_cleared", err_cnt, 8'd0);
        check("t5_err_idx_cleared", err_idx, 0);
        sb_drain("t5", l0);

        // reset while the sequencer waits for busy to fall
        clear_rom();
        rom[0] = e_wr(DEAD_ADDR, 8'h01);
        rom[1] = e_wr(8'h50, 8'h77);
        m_delay = 2; m_len = 200;
        d0 = done_cnt;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (i2c_busy) seen = 1'b1;
        end
        check("t6_master_busy_seen", seen, 1'b1);
        repeat (3) tick();
        check("t6_err_before_rst", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy_after_rst", busy, 1'b0);
        check("t6_flags_after_rst", {wr_flag, rd_flag}, 2'b00);
        check("t6_err_after_rst", err, 1'b0);
        check("t6_err_cnt_after_rst", err_cnt, 8'd0);
        check("t6_err_idx_after_rst", err_idx, 0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (!m_active) seen = 1'b1;
        end
        check("t6_master_idle", seen, 1'b1);
        check("t6_no_done", done_cnt - d0, 0);
        rom[0] = e_wr(8'h52, 8'h44);
        rom[1] = 18'h0;
        m_len = 4;
        l0 = log_n;
        exp_q.push_back({8'h52, 8'h44});
        pulse_start();
        wait_done("t6_rerun", 200);
        check("t6_rerun_done", done_cnt - d0, 1);
        check("t6_rerun_err", err, 1'b0);
        sb_drain("t6", l0);

        // global protocol checks
        check("flags_never_both", both_hi, 0);
        check("flags_only_when_busy", stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
